// File: rtl/wb_pkg.sv
// Shared Wishbone types: burst-target FSM states and the request/response
// records also used by the interconnect.
package wb_pkg;
   localparam int WB_WORD_BYTES = 4;
   localparam int WB_BL_W       = 10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_BURST = 3'd1,
      ST_RD_BURST = 3'd2,
      ST_ERR      = 3'd3,
      ST_DONE     = 3'd4
   } wbt_state_e;

   typedef struct packed {
      logic [31:0]        dat;
      logic [31:0]        adr;
      logic [3:0]         sel;
      logic [WB_BL_W-1:0] bl;
      logic               bry;
      logic               we;
      logic               cyc;
      logic               stb;
   } wb_req_t;

   typedef struct packed {
      logic [31:0] dat;
      logic        ack;
      logic        lack;
      logic        err;
   } wb_rsp_t;
endpackage

// File: rtl/wb_burst_target_if.sv
// Wishbone slave-port bundle with burst qualifiers (bl/bry) and last-beat ack.
interface wb_burst_target_if #(parameter int BL_W = 10);
   logic [31:0]     wbs_dat_i;
   logic [31:0]     wbs_adr_i;
   logic [3:0]      wbs_sel_i;
   logic [BL_W-1:0] wbs_bl_i;
   logic            wbs_bry_i;
   logic            wbs_we_i;
   logic            wbs_cyc_i;
   logic            wbs_stb_i;
   logic [31:0]     wbs_dat_o;
   logic            wbs_ack_o;
   logic            wbs_lack_o;
   logic            wbs_err_o;

   modport master (
      output wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bl_i, wbs_bry_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
      input  wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
   );

   modport slave (
      input  wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bl_i, wbs_bry_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
      output wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
   );
endinterface

// File: rtl/wb_burst_addr_gen.sv
// Burst address walker: loads start word and beat count, steps once per beat.
module wb_burst_addr_gen #(
   parameter int MEM_AW = 8,
   parameter int BL_W   = 10
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [MEM_AW-1:0] start_addr,
   input  logic [BL_W-1:0]   beats,
   output logic [MEM_AW-1:0] cur_addr,
   output logic [BL_W-1:0]   remaining,
   output logic              last,
   output logic              empty
);
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         remaining <= '0;
      end else if (load) begin
         cur_addr  <= start_addr;
         remaining <= beats;
      end else if (step) begin
         cur_addr  <= cur_addr + MEM_AW'(1);
         remaining <= remaining - BL_W'(1);
      end
   end

   assign last  = (remaining == BL_W'(1));
   assign empty = (remaining == '0);
endmodule

// File: rtl/wb_burst_target.sv
// Wishbone burst responder: turns bl/bry bursts into single-port SRAM word
// accesses; writes ack combinationally, reads ack one cycle after issue.
module wb_burst_target
   import wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_AW    = 8,
   parameter int          BL_W      = 10
) (
   input  logic              clk_i,
   input  logic              rst_n,
   wb_burst_target_if.slave  wbs,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);
   localparam int WSH = $clog2(WB_WORD_BYTES);

   wbt_state_e        state, state_nxt;
   logic              req_go, range_err;
   logic [31:0]       off;
   logic [BL_W-1:0]   n_beats;
   logic [32:0]       span;
   logic [MEM_AW-1:0] cur_addr;
   logic [BL_W-1:0]   remaining;
   logic              last, empty;
   logic              wr_beat, rd_issue;
   logic              rd_ack_q, rd_lack_q;
   wb_rsp_t           rsp;

   assign req_go  = wbs.wbs_cyc_i & wbs.wbs_stb_i;
   assign off     = wbs.wbs_adr_i - BASE_ADDR;
   assign n_beats = (wbs.wbs_bl_i == '0) ? BL_W'(1) : wbs.wbs_bl_i;
   // Wide sum so an overflowing burst is caught instead of wrapping the window
   assign span      = 33'(off >> WSH) + 33'(n_beats);
   assign range_err = (wbs.wbs_adr_i < BASE_ADDR) || (span > (33'(1) << MEM_AW));

   assign wr_beat  = rst_n && (state == ST_WR_BURST) && req_go && wbs.wbs_bry_i;
   assign rd_issue = rst_n && (state == ST_RD_BURST) && wbs.wbs_cyc_i && wbs.wbs_bry_i && !empty;

   wb_burst_addr_gen #(.MEM_AW(MEM_AW), .BL_W(BL_W)) u_addr_gen (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .load       ((state == ST_IDLE) && req_go),
      .step       (wr_beat | rd_issue),
      .start_addr (MEM_AW'(off >> WSH)),
      .beats      (n_beats),
      .cur_addr   (cur_addr),
      .remaining  (remaining),
      .last       (last),
      .empty      (empty)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (req_go) state_nxt = range_err ? ST_ERR :
                                              (wbs.wbs_we_i ? ST_WR_BURST : ST_RD_BURST);
         ST_WR_BURST: if (wr_beat && last) state_nxt = ST_DONE;
         ST_RD_BURST: if (rd_lack_q) state_nxt = ST_DONE;
         ST_ERR:      state_nxt = ST_DONE;
         ST_DONE:     if (!wbs.wbs_stb_i) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
      if (state != ST_IDLE && !wbs.wbs_cyc_i) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rd_ack_q  <= 1'b0;
         rd_lack_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         rd_ack_q  <= rd_issue;
         rd_lack_q <= rd_issue & last;
      end
   end

   // Read data is taken straight from the backend in the registered-ack cycle;
   // dropping cyc squashes an ack still in flight.
   always_comb begin
      rsp = '0;
      if (wr_beat) begin
         rsp.ack  = 1'b1;
         rsp.lack = last;
      end
      if (rst_n && rd_ack_q && wbs.wbs_cyc_i) begin
         rsp.dat  = mem_rdata_i;
         rsp.ack  = 1'b1;
         rsp.lack = rd_lack_q;
      end
      rsp.err = rst_n && (state == ST_ERR);
   end

   assign wbs.wbs_dat_o  = rsp.dat;
   assign wbs.wbs_ack_o  = rsp.ack;
   assign wbs.wbs_lack_o = rsp.lack;
   assign wbs.wbs_err_o  = rsp.err;

   assign mem_req_o   = wr_beat | rd_issue;
   assign mem_we_o    = wr_beat;
   assign mem_addr_o  = mem_req_o ? cur_addr : '0;
   assign mem_be_o    = wr_beat ? wbs.wbs_sel_i : 4'h0;
   assign mem_wdata_o = wr_beat ? wbs.wbs_dat_i : 32'h0;
endmodule

// File: doc/wb_burst_target.md
Name: wb_burst_target

Overview:
- Wishbone burst responder; terminates one slave port of the wb_interconnect.
- Accepts cyc/stb requests carrying burst length (bl) and burst-ready (bry) qualifiers, and converts them into a sequence of word accesses on a single-port synchronous SRAM-style backend.
- Returns per-beat ack, last-beat lack, and err for out-of-range requests.
- Sits behind the sync_wbb staging flops of the slave port. Drives the memory macro wrapper or a register-file backend.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0 of the backend.
- MEM_AW, 8, backend word-address width; window size is 2**MEM_AW words.
- BL_W, 10, width of the burst-length field.

Ports:
- clk_i  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address; bits [1:0] ignored
- wbs_sel_i  in  4  byte enables
- wbs_bl_i  in  BL_W  burst length in beats; 0 is treated as 1
- wbs_bry_i  in  1  burst ready: write data valid / read data accept
- wbs_we_i  in  1  1 = write
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  beat acknowledge
- wbs_lack_o  out  1  last-beat acknowledge; coincident with the final ack
- wbs_err_o  out  1  error termination
- mem_req_o  out  1  backend access strobe
- mem_we_o  out  1  backend write
- mem_addr_o  out  MEM_AW  backend word address
- mem_be_o  out  4  backend byte enables
- mem_wdata_o  out  32  backend write data
- mem_rdata_i  in  32  backend read data; valid exactly 1 cycle after a read mem_req_o

Behaviour:
- Reset:
  - All outputs are 0 while rst_n is low at a clk_i edge.
  - State returns to IDLE and the counters clear.
  - Reset asserted mid-burst aborts the burst immediately; no further mem_req_o.
- States: IDLE, WR_BURST, RD_BURST, ERR, DONE.
- IDLE:
  - Waits for cyc&stb.
  - Latches word address = (adr - BASE_ADDR)>>2, beat count N = (bl==0 ? 1 : bl), we, sel.
  - Range check: start < BASE_ADDR, or start word + N > 2**MEM_AW, goes to ERR.
  - Otherwise goes to WR_BURST or RD_BURST.
- WR_BURST:
  - Each cycle with cyc&stb&bry is one beat.
  - mem_req_o=1, mem_we_o=1, mem_addr_o=cur addr, mem_wdata_o=wbs_dat_i, mem_be_o=wbs_sel_i.
  - wbs_ack_o=1 in the same cycle; this path is combinational from registered state.
  - cur addr += 1 and remaining -= 1 per beat.
  - On the beat where remaining==1, wbs_lack_o=1 together with ack, then go to DONE.
  - bry low: no beat, no ack, state held.
- RD_BURST:
  - A read is issued (mem_req_o=1, mem_we_o=0) on each cycle where bry is high and issued<N.
  - wbs_dat_o/wbs_ack_o are registered: the ack comes 1 cycle after the issue, with mem_rdata_i.
  - Sustained throughput is 1 beat/cycle while bry stays high.
  - The lack is registered with the Nth ack; the cycle after it the state goes to DONE.
  - bry dropping stops issue only; a read already in flight still acks next cycle.
- ERR:
  - wbs_err_o=1 for exactly one cycle.
  - No ack, no mem access; then go to DONE.
- DONE:
  - Outputs 0; waits for stb low, then goes to IDLE.
  - Prevents a held stb from starting a second burst.
- cyc low in any non-IDLE state goes to IDLE next cycle.
  - No new mem_req_o from that cycle onward.
  - An in-flight read ack is suppressed.
- Address arithmetic:
  - Unsigned, MEM_AW bits.
  - Wrap cannot occur because the range check rejects overflowing bursts.
- ack, lack and err are never asserted simultaneously except the ack+lack pair.

Decomposition:
- Shared package (wb_pkg) holds:
  - the state enum type for this block;
  - the WB request struct (dat, adr, sel, bl, bry, we, cyc, stb) and response struct (dat, ack, lack, err), reused by the interconnect;
  - the constant WB_WORD_BYTES=4.
- Optional sub-module wb_burst_addr_gen: start address, beat counter, increment, last-beat flag.
- Everything else stays flat.

Test Plan:
- Single write: adr=BASE+0x10, bl=1, sel=4'hF, dat=32'hDEAD_BEEF, bry=1 -> one ack with lack, mem write addr=4 be=F; then a single read of the same address -> ack+lack 1 cycle after issue, dat_o=32'hDEAD_BEEF.
- Burst write then read: bl=4 at BASE+0, data 1..4 with bry held high -> 4 acks on consecutive cycles, lack on the 4th. Readback bl=4 -> dat_o 1,2,3,4 on consecutive acks, lack with 4.
- Read backpressure: bl=3 with bry low on cycle 2 only -> exactly 3 acks, no issue while bry low, correct data order, lack on the 3rd.
- Range error: adr=BASE+(2**MEM_AW-2)*4, bl=4 -> single err pulse, zero mem_req_o, return to IDLE after stb drops.
- Abort: bl=8 read, cyc dropped after the 3rd ack -> no further mem_req_o, at most 1 trailing ack suppressed, IDLE; a following bl=1 write succeeds.
- Mid-burst reset: rst_n low during the 2nd beat of a bl=4 write -> all outputs 0 next edge, remaining beats not written (memory unchanged at addr 2,3).
